// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one radix-2 step per cycle on operand magnitudes.
// Latency XLEN+1 cycles from start, or 1 cycle for divide special cases; start is ignored while busy.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_in_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_out_o
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;

  // Operand decode in IDLE: which operands are signed for this funct3
  logic            is_div, sgn_a, sgn_b, a_neg, b_neg, special;
  logic [XLEN-1:0] mag_a, mag_b;

  assign is_div  = funct3_i[2];
  assign sgn_a   = is_div ? ~funct3_i[0] : (funct3_i[1:0] == 2'b01 || funct3_i[1:0] == 2'b10);
  assign sgn_b   = is_div ? ~funct3_i[0] : (funct3_i[1:0] == 2'b01);
  assign a_neg   = sgn_a & rs1_data_i[XLEN-1];
  assign b_neg   = sgn_b & rs2_data_i[XLEN-1];
  assign mag_a   = a_neg ? -rs1_data_i : rs1_data_i;
  assign mag_b   = b_neg ? -rs2_data_i : rs2_data_i;
  assign special = is_div & ((rs2_data_i == '0) |
                   (~funct3_i[0] & (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2_data_i)));

  // Datapath step: {hi,lo} holds product (multiply) or remainder/quotient (divide)
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, final_res;

  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  assign div_sh   = {hi_q, lo_q[XLEN-1]};
  assign div_diff = div_sh - {1'b0, b_q};
  assign prod_s   = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign quo_s    = neg_q ? -lo_q : lo_q;
  assign rem_s    = neg_q ? -hi_q : hi_q;
  assign final_res = op_q[2] ? (op_q[1] ? rem_s : quo_s)
                             : ((op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    result_d = result_q;
    rd_out_d = rd_out_q;
    case (state_q)
      IDLE: begin
        if (start_i && !kill_i) begin
          op_d = funct3_i;
          rd_d = rd_in_i;
          b_d  = mag_b;
          if (special) begin
            // Special results are staged where the normal path leaves quotient/remainder
            state_d = DONE;
            neg_d   = 1'b0;
            lo_d    = (rs2_data_i == '0) ? '1 : rs1_data_i;
            hi_d    = (rs2_data_i == '0) ? rs1_data_i : '0;
          end else begin
            state_d = CALC;
            cnt_d   = CW'(XLEN - 1);
            neg_d   = (funct3_i[2] & funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
            lo_d    = mag_a;
            hi_d    = '0;
          end
        end
      end
      CALC: begin
        if (kill_i) begin
          state_d = IDLE;
        end else begin
          if (op_q[2]) begin
            if (!div_diff[XLEN]) begin
              hi_d = div_diff[XLEN-1:0];
              lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
              hi_d = div_sh[XLEN-1:0];
              lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
          end else begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
          end
          if (cnt_q == '0) state_d = DONE;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!kill_i) begin
          done_d   = 1'b1;
          result_d = final_res;
          rd_out_d = rd_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign done_o   = done_q;
  assign result_o = result_q;
  assign rd_out_o = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, corner-case sequences,
// and random operations checked against a plain-arithmetic reference model.
module tb_muldiv_unit;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i, kill_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_data_i, rs2_data_i;
  logic [4:0]  rd_in_i;
  logic        busy_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_out_o;

  muldiv_unit #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .kill_i(kill_i),
    .funct3_i(funct3_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .rd_in_i(rd_in_i), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o), .rd_out_o(rd_out_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_calc(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p  = 0;
    case (f3)
      3'd0: p = sa * sb;
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb;
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb;
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub;
      end
    endcase
    return p[31:0];
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  // Called #1 after a rising edge with the unit idle; returns #1 after the edge that raised done.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                        output int lat);
    funct3_i = f3; rs1_data_i = a; rs2_data_i = b; rd_in_i = rd; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    funct3_i = 3'($urandom); rs1_data_i = $urandom; rs2_data_i = $urandom; rd_in_i = 5'($urandom);
    lat = 0;
    while (!done_o && lat < 40) begin
      @(posedge clk_i); #1;
      lat++;
    end
    res = result_o;
    rdo = rd_out_o;
  endtask

  logic [31:0] res;
  logic [4:0]  rdo;
  int          lat, dones;
  logic [2:0]  rf3;
  logic [31:0] ra, rb;
  logic [4:0]  rrd;

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; kill_i = 1'b0; funct3_i = '0;
    rs1_data_i = '0; rs2_data_i = '0; rd_in_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_busy",   32'(busy_o),   32'd0);
    check("reset_done",   32'(done_o),   32'd0);
    check("reset_result", result_o,      32'd0);
    check("reset_rd",     32'(rd_out_o), 32'd0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33};
    vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 33};
    vecs[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 33};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         5'd8,  32'hFFFF_FFFF, 33};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD, 33};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF, 33};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,         5'd11, 32'd14,        33};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,         5'd12, 32'd2,         33};
    vecs[8]  = '{3'd4, 32'd55,         32'd0,         5'd13, 32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'd7, 32'h1234,       32'd0,         5'd14, 32'h1234,      1};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'h0000_0000, 1};
    vecs[12] = '{3'd1, 32'h8000_0000,  32'h8000_0000, 5'd17, 32'h4000_0000, 33};
    vecs[13] = '{3'd4, 32'h8000_0000,  32'd1,         5'd18, 32'h8000_0000, 33};
    vecs[14] = '{3'd6, 32'hFFFF_FF9C,  32'd0,         5'd19, 32'hFFFF_FF9C, 1};
    vecs[15] = '{3'd0, 32'h0001_0000,  32'h0001_0000, 5'd31, 32'h0000_0000, 33};

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, res, rdo, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_rd", i), 32'(rdo), 32'(vecs[i].rd));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      @(posedge clk_i); #1;
      check($sformatf("vec%0d_pulse", i), 32'(done_o), 32'd0);
    end

    // Asynchronous reset in the middle of a multiply
    run_op(3'd0, 32'd3, 32'd5, 5'd3, res, rdo, lat);
    check("pre_reset_result", res, 32'd15);
    funct3_i = 3'd0; rs1_data_i = 32'd9; rs2_data_i = 32'd9; rd_in_i = 5'd4; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #3 rst_ni = 1'b0;
    #1;
    check("midreset_busy",   32'(busy_o),   32'd0);
    check("midreset_done",   32'(done_o),   32'd0);
    check("midreset_result", result_o,      32'd0);
    check("midreset_rd",     32'(rd_out_o), 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    dones = 0;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (done_o) dones++;
    end
    check("midreset_no_done", 32'(dones), 32'd0);

    // Second start during a DIVU is ignored
    funct3_i = 3'd5; rs1_data_i = 32'd1000; rs2_data_i = 32'd3; rd_in_i = 5'd21; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    dones = 0; lat = 0; res = '0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 10) begin
        funct3_i = 3'd0; rs1_data_i = 32'd5; rs2_data_i = 32'd6; rd_in_i = 5'd1; start_i = 1'b1;
      end
      @(posedge clk_i); #1;
      start_i = 1'b0;
      if (done_o) begin
        dones++;
        lat = c;
        res = result_o;
      end
    end
    check("ignored_start_dones",   32'(dones), 32'd1);
    check("ignored_start_latency", 32'(lat),   32'd33);
    check("ignored_start_result",  res,        32'd333);

    // Kill at cycle 20 of a divide
    funct3_i = 3'd5; rs1_data_i = 32'd77; rs2_data_i = 32'd5; rd_in_i = 5'd22; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (19) @(posedge clk_i);
    #1 kill_i = 1'b1;
    @(posedge clk_i); #1;
    kill_i = 1'b0;
    check("kill_busy", 32'(busy_o), 32'd0);
    dones = 0;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (done_o) dones++;
    end
    check("kill_no_done",     32'(dones), 32'd0);
    check("kill_result_hold", result_o,   32'd333);
    run_op(3'd7, 32'd77, 32'd5, 5'd23, res, rdo, lat);
    check("after_kill_result",  res,       32'd2);
    check("after_kill_latency", 32'(lat),  32'd33);

    // start together with kill in IDLE is not accepted
    @(posedge clk_i); #1;
    funct3_i = 3'd0; start_i = 1'b1; kill_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0; kill_i = 1'b0;
    check("start_with_kill_busy", 32'(busy_o), 32'd0);

    // Random operations against the reference model
    for (int i = 0; i < 150; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      rrd = 5'($urandom);
      run_op(rf3, ra, rb, rrd, res, rdo, lat);
      check($sformatf("rand%0d_f3_%0d_%h_%h", i, rf3, ra, rb), res, ref_calc(rf3, ra, rb));
      check($sformatf("rand%0d_rd", i), 32'(rdo), 32'(rrd));
      check($sformatf("rand%0d_latency", i), 32'(lat), 32'(ref_lat(rf3, ra, rb)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
